hazard_scoreboard: RTL

- Parametrised successor to the pipeline load-use/branch hazard logic in the core controllers.
- Keeps a per-register scoreboard of pending writebacks with countdown timers, so any producer latency is handled: loads, CSR reads, and multi-cycle mul/div.
- Produces the ID-stage stall, the IF/ID and ID/EXE flushes, and a WAW interlock.
- Sits beside the decode stage and is driven by decode fields plus the MEM-stage branch/redirect resolution.

---
 rtl/hazard_scoreboard_pkg.sv | 15 +
 rtl/hazard_scoreboard_sb_entry.sv | 18 +
 rtl/hazard_scoreboard.sv | 97 +++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared sizes, latency classes and register index type for the hazard scoreboard
package hazard_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_AW = 5;
  localparam int MAX_LAT = 7;
  localparam int CNT_W = $clog2(MAX_LAT + 1);
  typedef enum logic [CNT_W-1:0] {
    LAT_ALU  = CNT_W'(0),
    LAT_LOAD = CNT_W'(1),
    LAT_MUL  = CNT_W'(3),
    LAT_DIV  = CNT_W'(MAX_LAT)
  } lat_class_e;
  localparam lat_class_e LAT_CSR = LAT_LOAD;
  typedef logic [REG_AW-1:0] reg_idx_t;
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// sb_entry: one pending-writeback countdown with clear > set > decrement priority
module sb_entry #(
  parameter int CNT_W = hazard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             set,
  input  logic [CNT_W-1:0] set_val,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = clr ? '0 : set ? set_val : (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register writeback scoreboard driving stall/flush/WAW interlock (perf counters via HAZARD_SB_PERF_EN)
module hazard_scoreboard #(
  parameter int NUM_REGS = hazard_pkg::NUM_REGS,
  parameter int REG_AW   = hazard_pkg::REG_AW,
  parameter int MAX_LAT  = hazard_pkg::MAX_LAT,
  parameter int CNT_W    = $clog2(MAX_LAT + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [REG_AW-1:0]             id_rs1,
  input  logic [REG_AW-1:0]             id_rs2,
  input  logic                          id_use_rs1,
  input  logic                          id_use_rs2,
  input  logic [REG_AW-1:0]             id_rd,
  input  logic                          id_wr_en,
  input  logic [CNT_W-1:0]              id_lat,
  input  logic                          redirect_mem,
  output logic                          stall_id,
  output logic                          flush_if_id,
  output logic                          flush_id_exe,
  output logic                          issue,
  output logic [$clog2(NUM_REGS+1)-1:0] pending_cnt
`ifdef HAZARD_SB_PERF_EN
  ,
  output logic [31:0]                   perf_raw_stalls,
  output logic [31:0]                   perf_waw_stalls,
  output logic [31:0]                   perf_flushes
`endif
);
  import hazard_pkg::*;
  localparam int PW = $clog2(NUM_REGS + 1);
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] lat_sat;
  logic [REG_AW-1:0] exe_rd_d, exe_rd_q;
  logic exe_wr_d, exe_wr_q, raw, waw, hz, wr_issue;
  logic [PW-1:0] pend_d, pend_q;
  assign cnt[0] = '0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : gen_sb
    sb_entry #(.CNT_W(CNT_W)) u_sb (
      .clk(clk),
      .rst_n(rst_n),
      .clr(redirect_mem & exe_wr_q & (exe_rd_q == REG_AW'(r))),
      .set(wr_issue & (id_rd == REG_AW'(r))),
      .set_val(lat_sat),
      .cnt(cnt[r])
    );
  end
  always_comb begin
    lat_sat = (32'(id_lat) > MAX_LAT) ? CNT_W'(MAX_LAT) : id_lat;
    raw = id_valid & ((id_use_rs1 & (id_rs1 != '0) & (cnt[id_rs1] != '0)) |
                      (id_use_rs2 & (id_rs2 != '0) & (cnt[id_rs2] != '0)));
    waw = id_valid & id_wr_en & (id_rd != '0) & (cnt[id_rd] > lat_sat);
    hz = raw | waw;
    stall_id = hz & ~redirect_mem;
    flush_if_id = redirect_mem;
    flush_id_exe = redirect_mem | hz;
    issue = id_valid & ~hz & ~redirect_mem;
    wr_issue = issue & id_wr_en & (id_rd != '0);
    exe_rd_d = id_rd;
    exe_wr_d = wr_issue;
    pend_d = '0;
    for (int i = 1; i < NUM_REGS; i++) pend_d = pend_d + PW'(cnt[i] != '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exe_rd_q <= '0;
      exe_wr_q <= 1'b0;
      pend_q <= '0;
    end else begin
      exe_rd_q <= exe_rd_d;
      exe_wr_q <= exe_wr_d;
      pend_q <= pend_d;
    end
  assign pending_cnt = pend_q;
`ifdef HAZARD_SB_PERF_EN
  logic [31:0] praw_d, praw_q, pwaw_d, pwaw_q, pfl_d, pfl_q;
  always_comb begin
    praw_d = praw_q + 32'(raw & stall_id);
    pwaw_d = pwaw_q + 32'(waw & stall_id);
    pfl_d = pfl_q + 32'(redirect_mem);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      praw_q <= '0;
      pwaw_q <= '0;
      pfl_q <= '0;
    end else begin
      praw_q <= praw_d;
      pwaw_q <= pwaw_d;
      pfl_q <= pfl_d;
    end
  assign perf_raw_stalls = praw_q;
  assign perf_waw_stalls = pwaw_q;
  assign perf_flushes = pfl_q;
`endif
endmodule
